sar_search_ctrl: RTL and testbench

//   Successive-approximation search engine that drives the B side of a magnitude

---
 rtl/sar_search_ctrl_if.sv | 24 ++
 rtl/sar_search_ctrl.sv | 146 ++++++++++++++
 tb/tb_sar_search_ctrl.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/sar_search_ctrl_if.sv
// Handshake and comparator bundle for the SAR search controller.
interface sar_search_ctrl_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic             greater;
  logic             equal;
  logic             less;
  logic [WIDTH-1:0] trial;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             err;

  modport master (
    output start, greater, equal, less,
    input  trial, busy, done, result, err
  );

  modport slave (
    input  start, greater, equal, less,
    output trial, busy, done, result, err
  );
endinterface

// File: rtl/sar_search_ctrl.sv
// Binary-search controller driving a comparator B side, MSB first.
// Optional SAR_EARLY_EXIT_EN: stop as soon as the comparator reports equal.
module sar_search_ctrl #(
  parameter int WIDTH   = 4,
  parameter int CMP_LAT = 0
) (
  input  logic           clk,
  input  logic           rst_n,
  sar_search_ctrl_if.slave bus
);
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    DECIDE,
    DONE
  } state_t;

  state_t           state;
  state_t           nxt;
  logic [WIDTH-1:0] trial_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] result_q;
  logic [IW-1:0]    idx_q;
  logic [3:0]       cnt_q;
  logic             busy_q;
  logic             done_q;
  logic             err_q;

  logic             onehot;
  logic             last;
  logic             hit;
  logic             go;
  logic             dec;
  logic             fin;
  logic             ld_cnt;
  logic [WIDTH-1:0] cur_bit;
  logic [WIDTH-1:0] nxt_bit;
  logic [WIDTH-1:0] acc_n;

  assign onehot = (bus.greater & ~bus.equal & ~bus.less)
                | (~bus.greater & bus.equal & ~bus.less)
                | (~bus.greater & ~bus.equal & bus.less);
  assign last   = (idx_q == '0);

`ifdef SAR_EARLY_EXIT_EN
  assign hit = bus.equal;
`else
  assign hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: begin
        if (bus.start)
          nxt = (CMP_LAT == 0) ? DECIDE : SETTLE;
      end
      SETTLE: begin
        if (cnt_q == '0) nxt = DECIDE;
      end
      DECIDE: begin
        if (!onehot || hit || last)
          nxt = DONE;
        else
          nxt = (CMP_LAT == 0) ? DECIDE : SETTLE;
      end
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    go      = 1'b0;
    dec     = 1'b0;
    fin     = 1'b0;
    ld_cnt  = (nxt == SETTLE) && (state != SETTLE);
    cur_bit = WIDTH'(1) << idx_q;
    nxt_bit = WIDTH'(1) << (idx_q - IW'(1));
    acc_n   = acc_q & ~cur_bit;
    unique case (1'b1)
      (state == IDLE):   go  = bus.start;
      (state == DECIDE): dec = 1'b1;
      (state == DONE):   fin = 1'b1;
      default: ;
    endcase
    if (bus.greater || bus.equal)
      acc_n = acc_q | cur_bit;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      trial_q  <= '0;
      acc_q    <= '0;
      result_q <= '0;
      idx_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      done_q <= fin;
      if (ld_cnt)
        cnt_q <= 4'(CMP_LAT - 1);
      else if (state == SETTLE && cnt_q != '0)
        cnt_q <= cnt_q - 4'd1;
      if (go) begin
        busy_q  <= 1'b1;
        err_q   <= 1'b0;
        acc_q   <= '0;
        idx_q   <= IW'(WIDTH - 1);
        trial_q <= WIDTH'(1) << (WIDTH - 1);
      end
      if (dec) begin
        if (!onehot) begin
          err_q <= 1'b1;
        end else if (hit) begin
          acc_q <= trial_q;
        end else begin
          acc_q <= acc_n;
          if (!last) begin
            idx_q   <= idx_q - IW'(1);
            trial_q <= acc_n | nxt_bit;
          end
        end
      end
      // An error result is forced to zero rather than a partial estimate.
      if (fin) begin
        result_q <= err_q ? '0 : acc_q;
        busy_q   <= 1'b0;
      end
    end
  end

  assign bus.trial  = trial_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;
  assign bus.err    = err_q;
endmodule

// File: tb/tb_sar_search_ctrl.sv
// Randomized bench for sar_search_ctrl at CMP_LAT 0 and 2.
module tb_sar_search_ctrl;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       st  [2];
  bit         bad [2];
  logic [3:0] tgt [2];
  logic [3:0] tr  [2];
  logic [3:0] res [2];
  logic       bsy [2];
  logic       dn  [2];
  logic       er  [2];
  int         checks = 0;
  int         failures = 0;

  sar_search_ctrl_if #(.WIDTH(4)) i0 ();
  sar_search_ctrl_if #(.WIDTH(4)) i2 ();

  sar_search_ctrl #(.WIDTH(4), .CMP_LAT(0)) u0 (
    .clk(clk), .rst_n(rst_n), .bus(i0)
  );
  sar_search_ctrl #(.WIDTH(4), .CMP_LAT(2)) u2 (
    .clk(clk), .rst_n(rst_n), .bus(i2)
  );

  always #5 clk = ~clk;

  assign i0.start   = st[0];
  assign i0.greater = bad[0] | (tgt[0] > i0.trial);
  assign i0.less    = bad[0] | (tgt[0] < i0.trial);
  assign i0.equal   = !bad[0] && (tgt[0] == i0.trial);
  assign i2.start   = st[1];
  assign i2.greater = bad[1] | (tgt[1] > i2.trial);
  assign i2.less    = bad[1] | (tgt[1] < i2.trial);
  assign i2.equal   = !bad[1] && (tgt[1] == i2.trial);

  assign tr[0]  = i0.trial;
  assign res[0] = i0.result;
  assign bsy[0] = i0.busy;
  assign dn[0]  = i0.done;
  assign er[0]  = i0.err;
  assign tr[1]  = i2.trial;
  assign res[1] = i2.result;
  assign bsy[1] = i2.busy;
  assign dn[1]  = i2.done;
  assign er[1]  = i2.err;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // w: 0 -> CMP_LAT 0, 1 -> CMP_LAT 2; hold: extra cycles start stays high
  task automatic run(int w, logic [3:0] t, bit b, int hold);
    int         lat_c = (w == 0) ? 0 : 2;
    int         klast = 3;
    int         lat;
    int         per;
    logic [3:0] exp_tr [4];
    logic [3:0] mask;
    bit         glitch = 1'b0;
    for (int k = 0; k < 4; k++) begin
      mask = 4'hF << (4 - k);
      exp_tr[k] = (t & mask) | (4'd8 >> k);
    end
    if (b) klast = 0;
`ifdef SAR_EARLY_EXIT_EN
    else begin
      for (int k = 3; k >= 0; k--)
        if (exp_tr[k] == t) klast = k;
    end
`endif
    per = 1 + lat_c;
    lat = (klast + 1) * per + 1;
    @(negedge clk);
    tgt[w] = t;
    bad[w] = b;
    st[w]  = 1'b1;
    for (int n = 0; n <= lat; n++) begin
      @(posedge clk);
      #1;
      if (n == hold) st[w] = 1'b0;
      if (n == 0) chk("busy_start", bsy[w], 1);
      for (int k = 0; k <= klast; k++)
        if (n == (k + 1) * per - 1)
          chk($sformatf("trial%0d_t%0h", k, t), tr[w], exp_tr[k]);
      if (n < lat && (dn[w] || !bsy[w])) glitch = 1'b1;
      if (n == lat) begin
        chk("done", dn[w], 1);
        chk($sformatf("result_t%0h", t), res[w], b ? 4'h0 : t);
        chk("err", er[w], b);
        chk("busy_end", bsy[w], 0);
      end
    end
    chk("no_early_done", glitch, 0);
    bad[w] = 1'b0;
    @(posedge clk);
    #1;
    chk("done_pulse", dn[w], 0);
    repeat (2) @(posedge clk);
    #1;
    chk("result_held", res[w], b ? 4'h0 : t);
  endtask

  task automatic reset_abort();
    bit seen = 1'b0;
    @(negedge clk);
    tgt[0] = 4'hA;
    st[0]  = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    st[0] = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_trial", tr[0], 0);
    chk("rst_busy", bsy[0], 0);
    chk("rst_done", dn[0], 0);
    chk("rst_result", res[0], 0);
    chk("rst_err", er[0], 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 10; n++) begin
      @(posedge clk);
      #1;
      if (dn[0] || bsy[0]) seen = 1'b1;
    end
    chk("abort_quiet", seen, 0);
    chk("abort_result", res[0], 0);
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      st[i]  = 1'b0;
      bad[i] = 1'b0;
      tgt[i] = 4'h0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("reset_trial", tr[i], 0);
      chk("reset_busy", bsy[i], 0);
      chk("reset_done", dn[i], 0);
      chk("reset_result", res[i], 0);
      chk("reset_err", er[i], 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run(0, 4'hA, 1'b0, 0);
    run(0, 4'h0, 1'b0, 0);
    run(1, 4'hF, 1'b0, 0);
    run(0, 4'h5, 1'b1, 0);
    run(1, 4'h3, 1'b1, 0);
    run(0, 4'h8, 1'b0, 1);
    for (int i = 0; i < 12; i++) begin
      run(0, 4'($urandom_range(0, 15)), 1'b0, $urandom_range(0, 1));
      run(1, 4'($urandom_range(0, 15)), 1'b0, $urandom_range(0, 2));
    end
    reset_abort();
    run(1, 4'h1, 1'b0, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
